ucsbece154b_gshare_bp: RTL and testbench
========================================

// Module: ucsbece154b_gshare_bp
// PURPOSE
//  Parametrised gshare branch predictor with speculative global history and checkpointed recovery.
//  Sits between fetch (lookup) and execute (resolve/update) of the 5-stage RISC-V pipeline.
//  Predicts next fetch PC for branch/jal/jalr from a direct-mapped tagged BTB and a 2-bit-counter PHT.
//  Reports mispredict statistics.
// PARAMETERS
//  NUM_BTB_ENTRIES  32    BTB entries, power of 2
//  NUM_GHR_BITS     3     global history length, <= log2(NUM_PHT_ENTRIES)
//  NUM_PHT_ENTRIES  1024  PHT entries, power of 2, 2-bit saturating counters
//  RAS_DEPTH        8     return-stack entries, power of 2; only used with BP_RAS_EN
// PORTS
//  clk            in   1   clock
//  reset          in   1   reset, synchronous, active-high
//  pc_i           in   32  fetch PC
//  instr_i        in   32  fetched instruction
//  lookup_en_i    in   1   fetch advances this cycle (not stalled)
//  npc_o          out  32  predicted next PC
//  taken_o        out  1   prediction redirects fetch
//  phtidx_o       out  P   PHT index used (P = log2 PHT); carried down the pipe
//  ghr_o          out  G   GHR before this lookup's shift; carried down the pipe as checkpoint
//  upd_valid_i    in   1   resolved control instruction in EX
//  upd_pc_i       in   32  its PC
//  upd_target_i   in   32  its computed target
//  upd_isbranch_i in   1   conditional branch
//  upd_isjump_i   in   1   jal/jalr
//  upd_taken_i    in   1   actual outcome (1 for jumps)
//  upd_mispred_i  in   1   EX detected mispredict
//  upd_phtidx_i   in   P   PHT index checkpoint
//  upd_ghr_i      in   G   GHR checkpoint
//  mispred_cnt_o  out  32  mispredicts since reset, wraps
// BEHAVIOUR
//  - Reset: BTB valid bits cleared, all PHT counters = 2'b01 (weak NT), GHR = 0, cnt = 0.
//    Hence taken_o = 0 and npc_o = pc_i+4 the cycle after reset.
//  - Lookup (combinational):
//    - BTB idx = pc_i[2 +: log2 BTB], tag = remaining upper bits.
//    - hit = valid & tag match & opcode in {1100011, 1101111, 1100111}.
//    - phtidx_o = pc_i[2 +: P] ^ {zero-extended GHR}.
//    - taken_o = hit & (~isbranch_entry | PHT[phtidx_o][1]).
//    - npc_o = taken_o ? BTB target : pc_i+4.
//  - Speculative GHR, clocked:
//    - if lookup_en_i & hit & entry isbranch: GHR <= {GHR[G-2:0], PHT[phtidx_o][1]}.
//    - if upd_valid_i & upd_mispred_i & upd_isbranch_i: GHR <= {upd_ghr_i[G-2:0], upd_taken_i}.
//      Restore has priority over a same-cycle speculative shift.
//    - Jump mispredict: GHR <= upd_ghr_i.
//  - PHT update on upd_valid_i & upd_isbranch_i at upd_phtidx_i:
//    - saturating +1 if taken, else -1; 11 stays 11, 00 stays 00.
//  - BTB write on upd_valid_i & (upd_isjump_i | upd_taken_i): valid=1, tag, target, isbranch.
//    Not-taken branches never allocate.
//  - All table writes are registered: a same-cycle lookup of the same entry sees the old value.
//  - mispred_cnt_o increments on upd_valid_i & upd_mispred_i; 0xFFFFFFFF wraps to 0.
//  - Reset mid-operation discards all state; update inputs are ignored while reset = 1.
// CONFIGURATION
//  BP_RAS_EN defined:
//    - Adds a RAS_DEPTH circular return stack. Link registers are x1 and x5.
//    - jal/jalr with rd = link, on lookup_en_i: push pc_i+4.
//    - jalr with rs1 = link and rd = x0: pop; npc_o = top, taken_o = 1.
//    - jalr with rd = link and rs1 = link: pop then push in the same cycle.
//    - Overflow overwrites the oldest entry. Pop when empty: fall back to the BTB path; pointer unchanged.
//    - No RAS repair on mispredict. Reset empties the stack.
//  BP_RAS_EN undefined: no stack; jalr is predicted by BTB only.
// TESTING
//  1. Reset, then pc_i=0x100 with a beq -> taken_o=0, npc_o=0x104, ghr_o=0.
//  2. Two taken updates of pc 0x100 (target 0x80) at the same phtidx, then lookup 0x100 with GHR=0
//     -> counter goes 01->10->11; taken_o=1, npc_o=0x80.
//  3. Mispredict restore, upd_ghr_i=3'b010, upd_taken_i=1, same cycle as a speculative shift
//     -> GHR=3'b101; mispred_cnt_o=1.
//  4. Three not-taken updates from 01 -> counter 00 and stays 00; no BTB allocation.
//  5. BTB entry allocated for 0x100, then lookup 0x180 (same index, different tag) -> taken_o=0, npc_o=0x184.
//  6. BP_RAS_EN: jal ra at 0x200, then jalr x0,0(ra) -> npc_o=0x204, taken_o=1.
//     Without the macro: npc_o=pc_i+4 on a BTB miss.

Source files
------------

// File: rtl/ucsbece154b_gshare_bp.sv
// Gshare branch predictor: direct-mapped tagged BTB, 2-bit counter PHT indexed by
// PC xor speculative global history, checkpointed history recovery on mispredict,
// and a wrapping mispredict counter.
// Optional return-address stack enabled by defining BP_RAS_EN.
module ucsbece154b_gshare_bp #(
    parameter int unsigned NUM_BTB_ENTRIES = 32,
    parameter int unsigned NUM_GHR_BITS    = 3,
    parameter int unsigned NUM_PHT_ENTRIES = 1024,
    parameter int unsigned RAS_DEPTH       = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    // Fetch-side lookup
    input  logic [31:0]                        pc_i,
    input  logic [31:0]                        instr_i,
    input  logic                               lookup_en_i,
    output logic [31:0]                        npc_o,
    output logic                               taken_o,
    output logic [$clog2(NUM_PHT_ENTRIES)-1:0] phtidx_o,
    output logic [NUM_GHR_BITS-1:0]            ghr_o,
    // Execute-side resolve/update
    input  logic                               upd_valid_i,
    input  logic [31:0]                        upd_pc_i,
    input  logic [31:0]                        upd_target_i,
    input  logic                               upd_isbranch_i,
    input  logic                               upd_isjump_i,
    input  logic                               upd_taken_i,
    input  logic                               upd_mispred_i,
    input  logic [$clog2(NUM_PHT_ENTRIES)-1:0] upd_phtidx_i,
    input  logic [NUM_GHR_BITS-1:0]            upd_ghr_i,
    output logic [31:0]                        mispred_cnt_o
);

    localparam int unsigned BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);
    localparam int unsigned TAG_W     = 30 - BTB_IDX_W;
    localparam int unsigned PHT_IDX_W = $clog2(NUM_PHT_ENTRIES);
    localparam int unsigned G         = NUM_GHR_BITS;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // ---------------------------------------------------------------- state
    logic [NUM_BTB_ENTRIES-1:0] btb_valid_q;
    logic [TAG_W-1:0]           btb_tag_q  [NUM_BTB_ENTRIES];
    logic [31:0]                btb_tgt_q  [NUM_BTB_ENTRIES];
    logic                       btb_isbr_q [NUM_BTB_ENTRIES];
    logic [1:0]                 pht_q      [NUM_PHT_ENTRIES];
    logic [G-1:0]               ghr_q, ghr_d;
    logic [31:0]                mispred_cnt_q;

    // ---------------------------------------------------------------- lookup
    logic [BTB_IDX_W-1:0] btb_idx;
    logic [TAG_W-1:0]     btb_tag;
    logic                 is_ctrl;
    logic                 btb_hit;
    logic [PHT_IDX_W-1:0] ghr_ext;
    logic [PHT_IDX_W-1:0] pht_idx;
    logic                 pht_pred;
    logic                 btb_taken;
    logic [31:0]          pc_plus4;

    assign btb_idx  = pc_i[2 +: BTB_IDX_W];
    assign btb_tag  = pc_i[31 -: TAG_W];
    assign is_ctrl  = (instr_i[6:0] == OP_BRANCH) || (instr_i[6:0] == OP_JAL) ||
                      (instr_i[6:0] == OP_JALR);
    assign btb_hit  = btb_valid_q[btb_idx] && (btb_tag_q[btb_idx] == btb_tag) && is_ctrl;
    assign pc_plus4 = pc_i + 32'd4;

    // Zero-extend the history up to the PHT index width
    always_comb begin
        ghr_ext        = '0;
        ghr_ext[G-1:0] = ghr_q;
    end

    assign pht_idx   = pc_i[2 +: PHT_IDX_W] ^ ghr_ext;
    assign pht_pred  = pht_q[pht_idx][1];
    // Jumps in the BTB are always taken; branches follow the counter MSB
    assign btb_taken = btb_hit && (!btb_isbr_q[btb_idx] || pht_pred);

    assign phtidx_o      = pht_idx;
    assign ghr_o         = ghr_q;
    assign mispred_cnt_o = mispred_cnt_q;

`ifdef BP_RAS_EN
    // ---------------------------------------------------------------- return stack
    localparam int unsigned RAS_PTR_W = $clog2(RAS_DEPTH);

    logic [31:0]          ras_q [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ras_tos_q, ras_tos_d;   // next free slot
    logic [RAS_PTR_W:0]   ras_cnt_q, ras_cnt_d;
    logic [RAS_PTR_W-1:0] ras_top_ptr;
    logic [RAS_PTR_W-1:0] ras_wr_ptr;
    logic [31:0]          ras_top;
    logic                 ras_we;
    logic                 rd_link, rs1_link, is_jal, is_jalr;
    logic                 ras_push, ras_pop_req, ras_pop;

    assign is_jal      = (instr_i[6:0] == OP_JAL);
    assign is_jalr     = (instr_i[6:0] == OP_JALR);
    assign rd_link     = (instr_i[11:7] == 5'd1) || (instr_i[11:7] == 5'd5);
    assign rs1_link    = (instr_i[19:15] == 5'd1) || (instr_i[19:15] == 5'd5);
    assign ras_push    = (is_jal || is_jalr) && rd_link;
    assign ras_pop_req = is_jalr && rs1_link && ((instr_i[11:7] == 5'd0) || rd_link);
    // An empty stack never pops; the BTB path predicts instead
    assign ras_pop     = ras_pop_req && (ras_cnt_q != '0);
    assign ras_top_ptr = ras_tos_q - RAS_PTR_W'(1);
    assign ras_top     = ras_q[ras_top_ptr];

    // Stack pointer/occupancy next state; pop-then-push reuses the popped slot
    always_comb begin
        ras_wr_ptr = ras_pop ? ras_top_ptr : ras_tos_q;
        ras_tos_d  = ras_tos_q;
        ras_cnt_d  = ras_cnt_q;
        ras_we     = 1'b0;
        if (lookup_en_i) begin
            if (ras_push) begin
                ras_we    = 1'b1;
                ras_tos_d = ras_wr_ptr + RAS_PTR_W'(1);
                // Full push wraps over the oldest entry, occupancy saturates
                if (!ras_pop && (ras_cnt_q != (RAS_PTR_W + 1)'(RAS_DEPTH))) begin
                    ras_cnt_d = ras_cnt_q + (RAS_PTR_W + 1)'(1);
                end
            end else if (ras_pop) begin
                ras_tos_d = ras_top_ptr;
                ras_cnt_d = ras_cnt_q - (RAS_PTR_W + 1)'(1);
            end
        end
    end

    // Stack pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ras_tos_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_tos_q <= ras_tos_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    // Stack storage; contents are meaningless until pushed
    always_ff @(posedge clk) begin
        if (!reset && ras_we) begin
            ras_q[ras_wr_ptr] <= pc_plus4;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{instr_i[31:20], instr_i[14:12], pc_i[1:0], upd_pc_i[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{instr_i[31:7], pc_i[1:0], upd_pc_i[1:0]} ^ (RAS_DEPTH == 0);
`endif

    // Final prediction; a return-stack pop overrides the BTB
    always_comb begin
        taken_o = btb_taken;
        npc_o   = btb_taken ? btb_tgt_q[btb_idx] : pc_plus4;
`ifdef BP_RAS_EN
        if (ras_pop) begin
            taken_o = 1'b1;
            npc_o   = ras_top;
        end
`endif
    end

    // ---------------------------------------------------------------- history
    // Checkpoint restore beats a same-cycle speculative shift
    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid_i && upd_mispred_i && upd_isbranch_i) begin
            ghr_d = {upd_ghr_i[G-2:0], upd_taken_i};
        end else if (upd_valid_i && upd_mispred_i && upd_isjump_i) begin
            ghr_d = upd_ghr_i;
        end else if (lookup_en_i && btb_hit && btb_isbr_q[btb_idx]) begin
            ghr_d = {ghr_q[G-2:0], pht_pred};
        end
    end

    // History and mispredict counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q         <= '0;
            mispred_cnt_q <= '0;
        end else begin
            ghr_q <= ghr_d;
            if (upd_valid_i && upd_mispred_i) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    // ---------------------------------------------------------------- PHT
    logic [1:0] pht_old, pht_new;

    // Saturating 2-bit counter step for the resolved branch
    always_comb begin
        pht_old = pht_q[upd_phtidx_i];
        pht_new = pht_old;
        if (upd_taken_i && (pht_old != 2'b11)) begin
            pht_new = pht_old + 2'd1;
        end else if (!upd_taken_i && (pht_old != 2'b00)) begin
            pht_new = pht_old - 2'd1;
        end
    end

    // PHT storage, all counters start weakly not-taken
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PHT_ENTRIES; i++) begin
                pht_q[i] <= 2'b01;
            end
        end else if (upd_valid_i && upd_isbranch_i) begin
            pht_q[upd_phtidx_i] <= pht_new;
        end
    end

    // ---------------------------------------------------------------- BTB
    logic [BTB_IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0]     upd_tag;
    logic                 btb_we;

    assign upd_idx = upd_pc_i[2 +: BTB_IDX_W];
    assign upd_tag = upd_pc_i[31 -: TAG_W];
    // Not-taken branches never allocate
    assign btb_we  = upd_valid_i && (upd_isjump_i || upd_taken_i);

    // BTB valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            btb_valid_q <= '0;
        end else if (btb_we) begin
            btb_valid_q[upd_idx] <= 1'b1;
        end
    end

    // BTB payload, qualified by the valid bit
    always_ff @(posedge clk) begin
        if (!reset && btb_we) begin
            btb_tag_q[upd_idx]  <= upd_tag;
            btb_tgt_q[upd_idx]  <= upd_target_i;
            btb_isbr_q[upd_idx] <= upd_isbranch_i;
        end
    end

endmodule

// File: tb/tb_ucsbece154b_gshare_bp.sv
// Self-checking bench for ucsbece154b_gshare_bp: directed scenarios followed by
// randomized lookups/updates compared against a table-level reference model.
module tb_ucsbece154b_gshare_bp;

    localparam int unsigned NB = 32;
    localparam int unsigned G  = 3;
    localparam int unsigned NP = 1024;
    localparam int unsigned RD = 8;

    localparam logic [31:0] I_BEQ    = 32'h0000_0063;
    localparam logic [31:0] I_JAL0   = 32'h0000_006F;
    localparam logic [31:0] I_JALR2  = 32'h0001_0067;  // jalr x0,0(x2)
    localparam logic [31:0] I_ADDI   = 32'h0000_0013;
    localparam logic [31:0] I_JAL_RA = 32'h0000_00EF;  // jal ra
    localparam logic [31:0] I_RET    = 32'h0000_8067;  // jalr x0,0(ra)

    logic        clk, reset;
    logic [31:0] pc_i, instr_i, npc_o, upd_pc_i, upd_target_i, mispred_cnt_o;
    logic        lookup_en_i, taken_o;
    logic [9:0]  phtidx_o, upd_phtidx_i;
    logic [2:0]  ghr_o, upd_ghr_i;
    logic        upd_valid_i, upd_isbranch_i, upd_isjump_i, upd_taken_i, upd_mispred_i;

    ucsbece154b_gshare_bp #(
        .NUM_BTB_ENTRIES(NB), .NUM_GHR_BITS(G), .NUM_PHT_ENTRIES(NP), .RAS_DEPTH(RD)
    ) dut (
        .clk(clk), .reset(reset),
        .pc_i(pc_i), .instr_i(instr_i), .lookup_en_i(lookup_en_i),
        .npc_o(npc_o), .taken_o(taken_o), .phtidx_o(phtidx_o), .ghr_o(ghr_o),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_target_i(upd_target_i),
        .upd_isbranch_i(upd_isbranch_i), .upd_isjump_i(upd_isjump_i),
        .upd_taken_i(upd_taken_i), .upd_mispred_i(upd_mispred_i),
        .upd_phtidx_i(upd_phtidx_i), .upd_ghr_i(upd_ghr_i), .mispred_cnt_o(mispred_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain tables
    bit          m_valid [NB];
    logic [31:0] m_tag   [NB];
    logic [31:0] m_tgt   [NB];
    bit          m_isbr  [NB];
    int          m_pht   [NP];
    int          m_ghr;
    logic [31:0] m_cnt;
    logic [31:0] m_ras   [$];

    // Model predictions for the current lookup inputs
    bit          e_tk, e_hit, e_pred, e_pop, e_push;
    logic [31:0] e_np;
    int unsigned e_idx, e_bi;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) m_valid[i] = 0;
        for (int i = 0; i < NP; i++) m_pht[i] = 1;
        m_ghr = 0;
        m_cnt = 0;
        m_ras.delete();
    endfunction

    function automatic bit is_link(input int r);
        return (r == 1) || (r == 5);
    endfunction

    function automatic void model_eval();
        logic [6:0] opc;
        int rd, rs1;
        opc    = instr_i[6:0];
        rd     = int'(instr_i[11:7]);
        rs1    = int'(instr_i[19:15]);
        e_bi   = (pc_i >> 2) % NB;
        e_idx  = ((pc_i >> 2) % NP) ^ m_ghr;
        e_hit  = m_valid[e_bi] && (m_tag[e_bi] == (pc_i >> 7)) &&
                 (opc == 7'b1100011 || opc == 7'b1101111 || opc == 7'b1100111);
        e_pred = (m_pht[e_idx] >= 2);
        e_tk   = e_hit && (!m_isbr[e_bi] || e_pred);
        e_np   = e_tk ? m_tgt[e_bi] : pc_i + 4;
        e_push = 0;
        e_pop  = 0;
`ifdef BP_RAS_EN
        e_push = (opc == 7'b1101111 || opc == 7'b1100111) && is_link(rd);
        e_pop  = (opc == 7'b1100111) && is_link(rs1) && (rd == 0 || is_link(rd)) &&
                 (m_ras.size() > 0);
        if (e_pop) begin
            e_tk = 1;
            e_np = m_ras[m_ras.size() - 1];
        end
`endif
    endfunction

    // Apply one clock edge of architectural effects, using pre-edge predictions
    function automatic void model_update();
        int ub;
        if (upd_valid_i && upd_mispred_i && upd_isbranch_i)
            m_ghr = (int'(upd_ghr_i) * 2 + int'(upd_taken_i)) % 8;
        else if (upd_valid_i && upd_mispred_i && upd_isjump_i)
            m_ghr = int'(upd_ghr_i);
        else if (lookup_en_i && e_hit && m_isbr[e_bi])
            m_ghr = (m_ghr * 2 + int'(e_pred)) % 8;
        if (upd_valid_i && upd_isbranch_i) begin
            if (upd_taken_i) m_pht[upd_phtidx_i] = (m_pht[upd_phtidx_i] == 3) ? 3 : m_pht[upd_phtidx_i] + 1;
            else             m_pht[upd_phtidx_i] = (m_pht[upd_phtidx_i] == 0) ? 0 : m_pht[upd_phtidx_i] - 1;
        end
        if (upd_valid_i && (upd_isjump_i || upd_taken_i)) begin
            ub = (upd_pc_i >> 2) % NB;
            m_valid[ub] = 1;
            m_tag[ub]   = upd_pc_i >> 7;
            m_tgt[ub]   = upd_target_i;
            m_isbr[ub]  = upd_isbranch_i;
        end
        if (upd_valid_i && upd_mispred_i) m_cnt = m_cnt + 1;
        if (lookup_en_i) begin
            if (e_pop) void'(m_ras.pop_back());
            if (e_push) begin
                m_ras.push_back(pc_i + 4);
                if (m_ras.size() > RD) m_ras.delete(0);
            end
        end
    endfunction

    task automatic set_lookup(input logic [31:0] pc, input logic [31:0] ins, input logic en);
        pc_i = pc; instr_i = ins; lookup_en_i = en;
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic br, input logic jp, input logic tk, input logic mp,
                           input logic [9:0] idx, input logic [2:0] gh);
        upd_valid_i = v; upd_pc_i = pc; upd_target_i = tgt; upd_isbranch_i = br;
        upd_isjump_i = jp; upd_taken_i = tk; upd_mispred_i = mp; upd_phtidx_i = idx;
        upd_ghr_i = gh;
    endtask

    // Compare all outputs with the model, then advance one clock
    task automatic cycle();
        #1;
        model_eval();
        check("taken", {31'b0, taken_o}, {31'b0, e_tk});
        check("npc", npc_o, e_np);
        check("phtidx", {22'b0, phtidx_o}, e_idx);
        check("ghr", {29'b0, ghr_o}, m_ghr);
        check("mispred_cnt", mispred_cnt_o, m_cnt);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        set_lookup(32'h0, I_ADDI, 1'b0);
        set_upd(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();

        // 1: reset state
        set_lookup(32'h100, I_BEQ, 1'b1);
        #1;
        check("t1_taken", {31'b0, taken_o}, 32'd0);
        check("t1_npc", npc_o, 32'h104);
        check("t1_ghr", {29'b0, ghr_o}, 32'd0);
        check("t1_cnt", mispred_cnt_o, 32'd0);
        cycle();

        // 2: two taken updates saturate to 11, then predict taken
        set_lookup(32'h100, I_BEQ, 1'b0);
        set_upd(1, 32'h100, 32'h80, 1, 0, 1, 0, 10'h40, 3'b000);
        cycle();
        cycle();
        set_lookup(32'h100, I_BEQ, 1'b1);
        set_upd(1, 32'h100, 32'h80, 1, 0, 1, 1, 10'h40, 3'b010);
        #1;
        check("t2_taken", {31'b0, taken_o}, 32'd1);
        check("t2_npc", npc_o, 32'h80);

        // 3: restore wins over the same-cycle speculative shift
        cycle();
        #1;
        check("t3_ghr", {29'b0, ghr_o}, 32'h5);
        check("t3_cnt", mispred_cnt_o, 32'd1);

        // 5: same BTB index, different tag misses
        set_upd(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_lookup(32'h180, I_BEQ, 1'b1);
        #1;
        check("t5_taken", {31'b0, taken_o}, 32'd0);
        check("t5_npc", npc_o, 32'h184);
        cycle();

        // 4: not-taken updates floor at 00 and do not allocate
        set_lookup(32'h300, I_BEQ, 1'b0);
        set_upd(1, 32'h300, 32'h340, 1, 0, 0, 0, 10'h0C5, 3'b101);
        repeat (3) cycle();
        set_upd(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_lookup(32'h300, I_BEQ, 1'b1);
        #1;
        check("t4_noalloc_taken", {31'b0, taken_o}, 32'd0);
        check("t4_noalloc_npc", npc_o, 32'h304);
        cycle();
        // one taken step from 00 reaches only 01: still not taken
        set_lookup(32'h300, I_BEQ, 1'b0);
        set_upd(1, 32'h300, 32'h340, 1, 0, 1, 0, 10'h0C5, 3'b101);
        cycle();
        set_upd(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("t4_idx", {22'b0, phtidx_o}, 32'h0C5);
        check("t4_floor_taken", {31'b0, taken_o}, 32'd0);
        check("t4_floor_npc", npc_o, 32'h304);
        cycle();

        // 6: call then return
        set_lookup(32'h200, I_JAL_RA, 1'b1);
        cycle();
        set_lookup(32'h204, I_RET, 1'b1);
        #1;
`ifdef BP_RAS_EN
        check("t6_taken", {31'b0, taken_o}, 32'd1);
        check("t6_npc", npc_o, 32'h204);
`else
        check("t6_taken", {31'b0, taken_o}, 32'd0);
        check("t6_npc", npc_o, 32'h208);
`endif
        cycle();

        // Randomized lookups and updates against the model
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] lpc, upc, ins;
            logic        br, tk;
            lpc = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2);
            upc = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2);
            case ($urandom_range(0, 3))
                0:       ins = I_BEQ;
                1:       ins = I_JAL0;
                2:       ins = I_JALR2;
                default: ins = I_ADDI;
            endcase
            set_lookup(lpc, ins, ($urandom_range(0, 3) != 0));
            br = $urandom_range(0, 2) != 0;
            tk = br ? 1'($urandom_range(0, 1)) : 1'b1;
            set_upd(1'($urandom_range(0, 1)), upc, $urandom & 32'hFFFF_FFFC, br, !br, tk,
                    ($urandom_range(0, 3) == 0),
                    10'(((upc >> 2) % NP) ^ $urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            cycle();
        end

        // Reset mid-operation with live updates discards everything
        reset = 1'b1;
        set_upd(1, 32'h100, 32'h80, 1, 0, 1, 1, 10'h40, 3'b111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        set_upd(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_lookup(32'h100, I_JAL0, 1'b1);
        #1;
        check("rst_cnt", mispred_cnt_o, 32'd0);
        check("rst_ghr", {29'b0, ghr_o}, 32'd0);
        check("rst_taken", {31'b0, taken_o}, 32'd0);
        check("rst_npc", npc_o, 32'h104);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
